// File: rtl/pc_sequencer.sv
// Multi-cycle fetch / next-PC engine: fetches over imem req/ack and issues over valid/ready.
// Optional MIPS delay slot when BRANCH_DELAY_SLOT_EN is defined.
module pc_sequencer #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            pcsrc,
  input  logic            jump,
  input  logic            jr,
  input  logic [XLEN-1:0] signimm,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_addr,
  output logic            addr_err
);

  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  state_e          state_q;
  logic            imem_req_q;
  logic [XLEN-1:0] imem_addr_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic [XLEN-1:0] pc_q;
  logic            addr_err_q;

  logic [XLEN-1:0] pc4_c;
  logic [XLEN-1:0] target_c;
  logic            redirect_c;
  logic            misalign_c;
  logic [XLEN-1:0] next_pc_d;

`ifdef BRANCH_DELAY_SLOT_EN
  logic            slot_q;
  logic [XLEN-1:0] pend_q;
`endif

  // Redirect target resolution, priority jr > jump > pcsrc > sequential.
  always_comb begin
    pc4_c      = pc_q + WORD_BYTES;
    redirect_c = jr | jump | pcsrc;
    misalign_c = jr & (|jr_target[1:0]);
    target_c   = pc4_c;
    if (jr) begin
      target_c = {jr_target[XLEN-1:2], 2'b00};
    end else if (jump) begin
      target_c = {pc4_c[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      target_c = pc4_c + (signimm << 2);
    end
`ifdef BRANCH_DELAY_SLOT_EN
    // A retiring slot instruction always goes to the stored target; its own controls are ignored.
    next_pc_d = slot_q ? pend_q : pc4_c;
`else
    next_pc_d = target_c;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      addr_err_q    <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      slot_q        <= 1'b0;
      pend_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_FETCH;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= next_pc_d;
            imem_addr_q   <= next_pc_d;
            imem_req_q    <= 1'b1;
            state_q       <= S_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
            if (slot_q) begin
              slot_q <= 1'b0;
            end else begin
              if (redirect_c) begin
                slot_q <= 1'b1;
                pend_q <= target_c;
              end
              if (misalign_c) addr_err_q <= 1'b1;
            end
`else
            if (misalign_c) addr_err_q <= 1'b1;
`endif
          end
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign addr_err    = addr_err_q;
`ifdef BRANCH_DELAY_SLOT_EN
  assign link_addr   = pc_q + XLEN'(8);
`else
  assign link_addr   = pc_q + WORD_BYTES;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a small req/ack imem model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc, jump, jr;
  logic [31:0] signimm, jr_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        addr_err;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          ack_delay = 0;
  int          wcnt;
  logic [31:0] imem_word = 32'h0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pcsrc(pcsrc), .jump(jump), .jr(jr), .signimm(signimm), .jr_target(jr_target),
    .pc(pc), .link_addr(link_addr), .addr_err(addr_err)
  );

  // imem: answers after ack_delay cycles of continuous request
  assign imem_ack   = imem_req && (wcnt >= ack_delay);
  assign imem_rdata = imem_word;
  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic retire(input bit p, input bit j, input bit r,
                        input logic [31:0] imm, input logic [31:0] jt, output bit ok);
    wait_valid(ok);
    pcsrc = p; jump = j; jr = r; signimm = imm; jr_target = jt;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    pcsrc = 1'b0; jump = 1'b0; jr = 1'b0; signimm = '0; jr_target = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_ready = 1'b0;
    pcsrc = 1'b0; jump = 1'b0; jr = 1'b0; signimm = '0; jr_target = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req); else n_pass++;
    n_chk++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", imem_addr); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", instr_valid); else n_pass++;
    n_chk++; if (instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr); else n_pass++;
    n_chk++; if (pc !== 32'h0) $display("FAIL rst_pc got=%h exp=0", pc); else n_pass++;
    n_chk++; if (addr_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", addr_err); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a;
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        exp_a = 32'((k - 1) * 2);
        n_chk++; if (imem_req !== 1'b1) $display("FAIL seq_req c%0d got=%b exp=1", k, imem_req); else n_pass++;
        n_chk++; if (imem_addr !== exp_a) $display("FAIL seq_addr c%0d got=%h exp=%h", k, imem_addr, exp_a); else n_pass++;
        if (k == 7) instr_ready = 1'b0;
      end else begin
        n_chk++; if (imem_req !== 1'b0) $display("FAIL seq_req c%0d got=%b exp=0", k, imem_req); else n_pass++;
        n_chk++; if (instr_valid !== 1'b1) $display("FAIL seq_valid c%0d got=%b exp=1", k, instr_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_branch();
    bit ok;
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, ok);
    n_chk++; if (!ok) $display("FAIL br_timeout got=timeout exp=valid"); else n_pass++;
    n_chk++; if (imem_addr !== 32'h100) $display("FAIL br_setup got=%h exp=100", imem_addr); else n_pass++;
    wait_valid(ok);
    n_chk++; if (pc !== 32'h100) $display("FAIL br_pc got=%h exp=100", pc); else n_pass++;
    retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, ok);
    n_chk++; if (imem_addr !== 32'h0FC) $display("FAIL br_back got=%h exp=0fc", imem_addr); else n_pass++;
    n_chk++; if (imem_req !== 1'b1) $display("FAIL br_req got=%b exp=1", imem_req); else n_pass++;
  endtask

  task automatic test_jump();
    bit ok;
    imem_word = 32'h0800_0040;
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h4000_0010, ok);
    n_chk++; if (imem_addr !== 32'h4000_0010) $display("FAIL j_setup got=%h exp=40000010", imem_addr); else n_pass++;
    wait_valid(ok);
    n_chk++; if (!ok) $display("FAIL j_timeout got=timeout exp=valid"); else n_pass++;
    n_chk++; if (instr !== 32'h0800_0040) $display("FAIL j_instr got=%h exp=08000040", instr); else n_pass++;
    n_chk++; if (link_addr !== 32'h4000_0014) $display("FAIL j_link got=%h exp=40000014", link_addr); else n_pass++;
    imem_word = 32'h0;
    retire(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, ok);
    n_chk++; if (imem_addr !== 32'h4000_0100) $display("FAIL j_target got=%h exp=40000100", imem_addr); else n_pass++;
  endtask

  task automatic test_jr_err();
    bit ok;
    n_chk++; if (addr_err !== 1'b0) $display("FAIL jr_pre_err got=%b exp=0", addr_err); else n_pass++;
    retire(1'b1, 1'b0, 1'b1, 32'h10, 32'h203, ok);
    n_chk++; if (imem_addr !== 32'h200) $display("FAIL jr_align got=%h exp=200", imem_addr); else n_pass++;
    n_chk++; if (addr_err !== 1'b1) $display("FAIL jr_err got=%b exp=1", addr_err); else n_pass++;
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ok);
    n_chk++; if (imem_addr !== 32'h204) $display("FAIL jr_seq got=%h exp=204", imem_addr); else n_pass++;
    n_chk++; if (addr_err !== 1'b1) $display("FAIL jr_sticky got=%b exp=1", addr_err); else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    ack_delay = 3;
    imem_word = 32'h1234_5678;
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h208 || instr_valid !== 1'b0)
        $display("FAIL stall_fetch c%0d got=%b/%h/%b exp=1/208/0", i, imem_req, imem_addr, instr_valid);
      else n_pass++;
    end
    wait_valid(ok);
    n_chk++; if (instr !== 32'h1234_5678) $display("FAIL stall_instr got=%h exp=12345678", instr); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++; if (instr_valid !== 1'b1 || pc !== 32'h208 || instr !== 32'h1234_5678)
        $display("FAIL stall_issue c%0d got=%b/%h/%h exp=1/208/12345678", i, instr_valid, pc, instr);
      else n_pass++;
    end
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ok);
    n_chk++; if (imem_addr !== 32'h20C) $display("FAIL stall_next got=%h exp=20c", imem_addr); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_mid_req got=%b exp=0", imem_req); else n_pass++;
    n_chk++; if (addr_err !== 1'b0) $display("FAIL rst_mid_err got=%b exp=0", addr_err); else n_pass++;
    @(negedge clk);
    ack_delay = 0;
    imem_word = 32'h0;
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL refetch got=%b/%h exp=1/0", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_delay_slot();
    bit ok;
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h20, ok);
    n_chk++; if (imem_addr !== 32'h10) $display("FAIL ds_slot0 got=%h exp=10", imem_addr); else n_pass++;
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ok);
    n_chk++; if (imem_addr !== 32'h20) $display("FAIL ds_tgt0 got=%h exp=20", imem_addr); else n_pass++;
    wait_valid(ok);
    n_chk++; if (link_addr !== 32'h28) $display("FAIL ds_link got=%h exp=28", link_addr); else n_pass++;
    retire(1'b1, 1'b0, 1'b0, 32'h17, 32'h0, ok);
    n_chk++; if (imem_addr !== 32'h24) $display("FAIL ds_slot got=%h exp=24", imem_addr); else n_pass++;
    retire(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, ok);
    n_chk++; if (imem_addr !== 32'h80) $display("FAIL ds_target got=%h exp=80", imem_addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
`ifdef BRANCH_DELAY_SLOT_EN
    test_delay_slot();
`else
    test_branch();
    test_jump();
    test_jr_err();
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
